// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Write/read burst sequencer for a single-port registered RAM,
//               with a 2-entry read buffer for full rd_ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WRITE = 3'd1;
    localparam logic [2:0] c_READ  = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [LEN_WIDTH-1:0] c_MAX_LEN = LEN_WIDTH'(2**ADDR_WIDTH);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic                  r_outstanding;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    logic [1:0]            r_count;

    logic                  w_beat;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_level;
    logic [LEN_WIDTH-1:0]  w_len_clip;

    assign w_len_clip = (cmd_len > c_MAX_LEN) ? c_MAX_LEN : cmd_len;
    assign w_beat     = (r_state == c_WRITE) && wr_valid;
    assign w_pop      = rd_valid && rd_ready;

    // Occupancy after this cycle's pop; counting the pop keeps 1 word/cycle.
    assign w_level = {1'b0, r_count} + {2'b00, r_outstanding} - {2'b00, w_pop};
    assign w_issue = (r_state == c_READ) && (r_remain != '0) && (w_level < 3'd2);

    assign rd_valid = (r_count != 2'd0);
    assign rd_data  = r_rd_idx ? r_buf1 : r_buf0;
    assign busy     = (r_state != c_IDLE);
    assign done     = (r_state == c_DONE);
    assign ram_addr = r_ptr;

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        ram_we       = 1'b0;
        ram_d        = '0;
        case (r_state)
            c_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_len_clip == '0)
                        w_next_state = c_DONE;
                    else
                        w_next_state = cmd_write ? c_WRITE : c_READ;
                end
            end
            c_WRITE: begin
                wr_ready = 1'b1;
                if (w_beat) begin
                    ram_we = 1'b1;
                    ram_d  = wr_data;
                    if (r_remain == LEN_WIDTH'(1))
                        w_next_state = c_DONE;
                end
            end
            c_READ: begin
                if (w_issue && (r_remain == LEN_WIDTH'(1)))
                    w_next_state = c_DRAIN;
            end
            c_DRAIN: begin
                if (!r_outstanding && (r_count == 2'd0))
                    w_next_state = c_DONE;
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_ptr         <= '0;
            r_remain      <= '0;
            r_outstanding <= 1'b0;
            r_buf0        <= '0;
            r_buf1        <= '0;
            r_wr_idx      <= 1'b0;
            r_rd_idx      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            r_state       <= w_next_state;
            r_outstanding <= w_issue;
            if ((r_state == c_IDLE) && cmd_valid) begin
                r_ptr    <= cmd_addr;
                r_remain <= w_len_clip;
            end else if (w_beat || w_issue) begin
                r_ptr    <= r_ptr + ADDR_WIDTH'(1);
                r_remain <= r_remain - LEN_WIDTH'(1);
            end
            // RAM output is valid the cycle after the address was issued.
            if (r_outstanding) begin
                if (r_wr_idx)
                    r_buf1 <= ram_q;
                else
                    r_buf0 <= ram_q;
                r_wr_idx <= ~r_wr_idx;
            end
            if (w_pop)
                r_rd_idx <= ~r_rd_idx;
            r_count <= r_count + {1'b0, r_outstanding} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
